// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit FIFO slice.
package uart_pkg;
  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LAUNCH,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_fsm_e;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side push/status signals and UART transmitter handshake for uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  import uart_pkg::*;
  localparam int LW = $clog2(DEPTH) + 1;

  logic               wr_en;
  logic [UART_DW-1:0] wr_data;
  logic               flush;
  logic               wr_ready;
  logic               uart_wr_en;
  logic [UART_DW-1:0] uart_wr_data;
  logic               uart_tx_busy;
  logic [LW-1:0]      level;
  logic               empty;
  logic               full;
  logic               overflow;
  logic               tx_idle;

  modport master (
    output wr_en, wr_data, flush, uart_tx_busy,
    input  wr_ready, uart_wr_en, uart_wr_data, level, empty, full, overflow, tx_idle
  );

  modport slave (
    input  wr_en, wr_data, flush, uart_tx_busy,
    output wr_ready, uart_wr_en, uart_wr_data, level, empty, full, overflow, tx_idle
  );
endinterface

// File: rtl/sync_fifo.sv
// Byte FIFO: storage, wrap-around pointers, level, flags, sticky overflow and flush.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               push,
  input  logic [UART_DW-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [UART_DW-1:0] head,
  output logic [LW-1:0]      level,
  output logic               empty,
  output logic               full,
  output logic               overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [UART_DW-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer width equals log2(DEPTH), so natural rollover gives the modulo wrap.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push_ok) - LW'(pop_ok);
      if (push & full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a byte-wide UART: queues pushes and launches one byte per transfer.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int BUSY_WAIT = 4
) (
  input logic            clk,
  input logic            rstb,
  uart_tx_fifo_if.slave  bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(BUSY_WAIT + 1);

  tx_fsm_e            state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic               pop;
  logic               empty;
  logic               full;
  logic [UART_DW-1:0] head;
  logic [UART_DW-1:0] tx_data;
  logic [LW-1:0]      level;
  logic               overflow;

  sync_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk       (clk),
    .rstb      (rstb),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .flush     (bus.flush),
    .head      (head),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      tx_data <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (pop) tx_data <= head;
    end
  end

  // Flush only touches the FIFO; an in-flight transfer still runs to completion.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!empty && !bus.uart_tx_busy) begin
          pop      = 1'b1;
          state_nx = TX_LAUNCH;
        end
      end
      TX_LAUNCH: begin
        cnt_nx   = '0;
        state_nx = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (bus.uart_tx_busy)                 state_nx = TX_WAIT_DONE;
        else if (cnt == CW'(BUSY_WAIT - 1))   state_nx = TX_IDLE;
        else                                  cnt_nx   = cnt + 1'b1;
      end
      TX_WAIT_DONE: begin
        if (!bus.uart_tx_busy) state_nx = TX_IDLE;
      end
      default: state_nx = TX_IDLE;
    endcase
  end

  assign bus.uart_wr_en   = (state == TX_LAUNCH);
  assign bus.uart_wr_data = tx_data;
  assign bus.level        = level;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.wr_ready     = ~full;
  assign bus.overflow     = overflow;
  assign bus.tx_idle      = empty && (state == TX_IDLE);
endmodule
